button_uart_tx: RTL and testbench

Single-byte UART transmitter triggered by a one-cycle start pulse, normally the debounced `p_edge` of the push-button front end. Each press captures the `din` byte and serialises it as an 8N1 (or 8N2) frame on `tx`. A one-entry pending buffer absorbs a press that arrives mid-frame, and overflow is flagged. The block sits between the button conditioning stage and the board's UART TX pin or the loopback into the UART/FIFO receive path.

---
 rtl/button_uart_tx_if.sv | 35 +++
 rtl/button_uart_tx.sv | 173 +++++++++++++++++
 tb/tb_button_uart_tx.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/button_uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : button_uart_tx_if
// Description : Request/serial-status bundle for the button-triggered UART TX.
// Revision    : 1.0 - initial release
// ============================================================================
interface button_uart_tx_if #(
  parameter int DBITS = 8
);
  logic             start;
  logic [DBITS-1:0] din;
  logic             tx;
  logic             busy;
  logic             tx_done;
  logic             dropped;

  modport master (
    output start,
    output din,
    input  tx,
    input  busy,
    input  tx_done,
    input  dropped
  );

  modport slave (
    input  start,
    input  din,
    output tx,
    output busy,
    output tx_done,
    output dropped
  );
endinterface
`default_nettype wire

// File: rtl/button_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : button_uart_tx
// Description : Start-pulse triggered 8N1/8N2 UART transmitter with a
//               one-entry pending buffer and overflow (dropped) pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module button_uart_tx #(
  parameter int DBITS        = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  button_uart_tx_if.slave       bus
);

  localparam int c_BAUD_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int c_BIT_W    = (DBITS > 1) ? $clog2(DBITS) : 1;
  localparam int c_STOP_CYC = STOP_BITS * CLKS_PER_BIT;
  localparam int c_STOP_W   = (c_STOP_CYC > 1) ? $clog2(c_STOP_CYC) : 1;

  localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [c_BIT_W-1:0]  c_BIT_LAST  = c_BIT_W'(DBITS - 1);
  localparam logic [c_STOP_W-1:0] c_STOP_LAST = c_STOP_W'(c_STOP_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t               state_q,    state_d;
  logic [DBITS-1:0]     shift_q,    shift_d;
  logic [DBITS-1:0]     pend_q,     pend_d;
  logic                 pend_vld_q, pend_vld_d;
  logic [c_BAUD_W-1:0]  baud_q,     baud_d;
  logic [c_BIT_W-1:0]   bit_q,      bit_d;
  logic [c_STOP_W-1:0]  stop_q,     stop_d;
  logic                 tx_q,       tx_d;
  logic                 busy_q,     busy_d;
  logic                 done_q,     done_d;
  logic                 drop_q,     drop_d;
  logic                 w_frame_end;

  assign w_frame_end = (state_q == S_STOP) && (stop_q == c_STOP_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      baud_q     <= '0;
      bit_q      <= '0;
      stop_q     <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      stop_q     <= stop_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      drop_q     <= drop_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    stop_d     = stop_q;
    done_d     = 1'b0;
    drop_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          shift_d = bus.din;
          baud_d  = '0;
          state_d = S_START;
        end
      end

      S_START: begin
        if (baud_q == c_BAUD_LAST) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      S_DATA: begin
        if (baud_q == c_BAUD_LAST) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == c_BIT_LAST) begin
            bit_d   = '0;
            stop_d  = '0;
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      S_STOP: begin
        if (w_frame_end) begin
          stop_d = '0;
          baud_d = '0;
          done_d = 1'b1;
          // A queued byte always wins over a press landing on the last stop cycle.
          if (pend_vld_q) begin
            shift_d    = pend_q;
            pend_vld_d = 1'b0;
            state_d    = S_START;
            drop_d     = bus.start;
          end else if (bus.start) begin
            shift_d = bus.din;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          stop_d = stop_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if ((state_q != S_IDLE) && !w_frame_end && bus.start) begin
      if (pend_vld_q) begin
        drop_d = 1'b1;
      end else begin
        pend_d     = bus.din;
        pend_vld_d = 1'b1;
      end
    end

    // tx is registered from the next state so the line moves on the same edge as the FSM.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase

    busy_d = (state_d != S_IDLE) || pend_vld_d;
  end

  assign bus.tx      = tx_q;
  assign bus.busy    = busy_q;
  assign bus.tx_done = done_q;
  assign bus.dropped = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_button_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_uart_tx
// Description : Scoreboard bench: serial frames decoded by a monitor and
//               compared against bytes queued by the directed stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_uart_tx;

  logic clk;
  logic reset_n;

  button_uart_tx_if #(.DBITS(8)) bus0 ();
  button_uart_tx_if #(.DBITS(8)) bus1 ();

  button_uart_tx #(.DBITS(8), .CLKS_PER_BIT(4), .STOP_BITS(1)) dut0 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus0)
  );

  button_uart_tx #(.DBITS(8), .CLKS_PER_BIT(4), .STOP_BITS(2)) dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];

  bit          m_active [2];
  int          m_cnt    [2];
  logic [63:0] m_obs    [2];
  bit          m_early  [2];
  int          b2b_cnt  [2];
  int          drop_cnt [2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Expected line level for every cycle of a frame, bit c = cycle c (4 clocks per bit).
  function automatic logic [63:0] exp_frame(input logic [7:0] b, input int stopb);
    logic [63:0] v;
    int j;
    v = '0;
    for (int c = 0; c < (9 + stopb) * 4; c++) begin
      j = c / 4;
      if (j == 0)      v[c] = 1'b0;
      else if (j <= 8) v[c] = b[j-1];
      else             v[c] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic get_tx(input int d);
    return (d == 0) ? bus0.tx : bus1.tx;
  endfunction

  function automatic logic get_done(input int d);
    return (d == 0) ? bus0.tx_done : bus1.tx_done;
  endfunction

  function automatic logic get_drop(input int d);
    return (d == 0) ? bus0.dropped : bus1.dropped;
  endfunction

  task automatic mon_begin(input int d);
    m_active[d] = 1'b1;
    m_obs[d]    = '0;
    m_cnt[d]    = 1;
    m_early[d]  = 1'b0;
  endtask

  task automatic mon_step(input int d);
    int          len;
    logic [7:0]  b;
    logic        have;
    len = (d == 0) ? 40 : 44;
    if (!reset_n) begin
      m_active[d] = 1'b0;
      return;
    end
    if (get_drop(d)) drop_cnt[d]++;
    if (m_active[d] && m_cnt[d] == len) begin
      check($sformatf("tx_done_at_end%0d", d), 64'(get_done(d)), 64'd1);
      have = (d == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
      if (!have) begin
        check($sformatf("unexpected_frame%0d", d), m_obs[d], 64'd0 - 64'd1);
      end else begin
        b = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        check($sformatf("frame%0d_%0h", d, b), m_obs[d], exp_frame(b, (d == 0) ? 1 : 2));
        check($sformatf("no_early_done%0d_%0h", d, b), 64'(m_early[d]), 64'd0);
      end
      m_active[d] = 1'b0;
      if (get_tx(d) == 1'b0) begin
        b2b_cnt[d]++;
        mon_begin(d);
      end
    end else if (m_active[d]) begin
      m_obs[d][m_cnt[d]] = get_tx(d);
      if (get_done(d)) m_early[d] = 1'b1;
      m_cnt[d]++;
    end else if (get_tx(d) == 1'b0) begin
      mon_begin(d);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) mon_step(d);
  end

  // Caller sits just after a rising edge; the pulse is sampled on the next one.
  task automatic pulse_start(input int d, input logic [7:0] b);
    if (d == 0) begin bus0.start = 1'b1; bus0.din = b; end
    else        begin bus1.start = 1'b1; bus1.din = b; end
    @(posedge clk); #1;
    if (d == 0) bus0.start = 1'b0;
    else        bus1.start = 1'b0;
  endtask

  task automatic wait_empty(input int d, input int budget);
    int left;
    int sz;
    left = budget;
    sz = (d == 0) ? exp_q0.size() : exp_q1.size();
    while (sz != 0 && left > 0) begin
      @(posedge clk); #1;
      left--;
      sz = (d == 0) ? exp_q0.size() : exp_q1.size();
    end
    check($sformatf("queue_drained%0d", d), 64'(sz), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int b2b0, drop0, busy_low;
    for (int d = 0; d < 2; d++) begin
      m_active[d] = 1'b0; m_cnt[d] = 0; m_obs[d] = '0;
      m_early[d] = 1'b0; b2b_cnt[d] = 0; drop_cnt[d] = 0;
    end
    reset_n    = 1'b0;
    bus0.start = 1'b0; bus0.din = 8'h00;
    bus1.start = 1'b0; bus1.din = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx0",      64'(bus0.tx),      64'd1);
    check("rst_busy0",    64'(bus0.busy),    64'd0);
    check("rst_done0",    64'(bus0.tx_done), 64'd0);
    check("rst_dropped0", 64'(bus0.dropped), 64'd0);
    check("rst_tx1",      64'(bus1.tx),      64'd1);
    check("rst_busy1",    64'(bus1.busy),    64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Single frame 0xA5
    exp_q0.push_back(8'hA5);
    pulse_start(0, 8'hA5);
    check("single_tx_fall", 64'(bus0.tx),   64'd0);
    check("single_busy",    64'(bus0.busy), 64'd1);
    repeat (39) @(posedge clk);
    #1;
    check("single_done_not_yet", 64'(bus0.tx_done), 64'd0);
    @(posedge clk); #1;
    check("single_done_40", 64'(bus0.tx_done), 64'd1);
    check("single_busy_off", 64'(bus0.busy),   64'd0);
    wait_empty(0, 100);

    // Back-to-back 0x55 then 0x3C
    b2b0 = b2b_cnt[0];
    exp_q0.push_back(8'h55);
    exp_q0.push_back(8'h3C);
    pulse_start(0, 8'h55);
    repeat (10) @(posedge clk);
    #1;
    pulse_start(0, 8'h3C);
    busy_low = 0;
    for (int i = 0; i < 68; i++) begin
      @(posedge clk); #1;
      if (!bus0.busy) busy_low++;
    end
    check("b2b_busy_held", 64'(busy_low), 64'd0);
    @(posedge clk); #1;
    check("b2b_busy_off", 64'(bus0.busy), 64'd0);
    wait_empty(0, 100);
    check("b2b_no_gap", 64'(b2b_cnt[0] - b2b0), 64'd1);

    // Overflow: 0x11 in flight, 0x22 pending, 0x33 dropped
    drop0 = drop_cnt[0];
    exp_q0.push_back(8'h11);
    exp_q0.push_back(8'h22);
    pulse_start(0, 8'h11);
    repeat (4) @(posedge clk);
    #1;
    pulse_start(0, 8'h22);
    check("ovf_pending_no_drop", 64'(bus0.dropped), 64'd0);
    repeat (4) @(posedge clk);
    #1;
    pulse_start(0, 8'h33);
    check("ovf_dropped_pulse", 64'(bus0.dropped), 64'd1);
    wait_empty(0, 200);
    check("ovf_drop_count", 64'(drop_cnt[0] - drop0), 64'd1);

    // Start coincident with frame completion, pending empty
    drop0 = drop_cnt[0];
    b2b0  = b2b_cnt[0];
    exp_q0.push_back(8'h5A);
    exp_q0.push_back(8'h0F);
    pulse_start(0, 8'h5A);
    repeat (39) @(posedge clk);
    #1;
    pulse_start(0, 8'h0F);
    check("simul_done",       64'(bus0.tx_done), 64'd1);
    check("simul_tx_start",   64'(bus0.tx),      64'd0);
    check("simul_no_dropped", 64'(bus0.dropped), 64'd0);
    wait_empty(0, 200);
    check("simul_drop_count", 64'(drop_cnt[0] - drop0), 64'd0);
    check("simul_no_gap",     64'(b2b_cnt[0] - b2b0),   64'd1);

    // Reset during data bit 3 of 0xFF
    pulse_start(0, 8'hFF);
    repeat (16) @(posedge clk);
    #2;
    check("pre_rst_busy", 64'(bus0.busy), 64'd1);
    reset_n = 1'b0;
    #1;
    check("midrst_tx",   64'(bus0.tx),      64'd1);
    check("midrst_busy", 64'(bus0.busy),    64'd0);
    check("midrst_done", 64'(bus0.tx_done), 64'd0);
    exp_q0.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    exp_q0.push_back(8'h81);
    pulse_start(0, 8'h81);
    repeat (40) @(posedge clk);
    #1;
    check("post_rst_done_40", 64'(bus0.tx_done), 64'd1);
    wait_empty(0, 100);

    // Two stop bits on the second instance, byte 0x00
    exp_q1.push_back(8'h00);
    pulse_start(1, 8'h00);
    repeat (35) @(posedge clk);
    #1;
    check("stop2_last_low", 64'(bus1.tx), 64'd0);
    @(posedge clk); #1;
    check("stop2_first_high", 64'(bus1.tx), 64'd1);
    repeat (7) @(posedge clk);
    #1;
    check("stop2_done_not_yet", 64'(bus1.tx_done), 64'd0);
    @(posedge clk); #1;
    check("stop2_done_44", 64'(bus1.tx_done), 64'd1);
    check("stop2_busy_off", 64'(bus1.busy),   64'd0);
    wait_empty(1, 100);

    check("dut1_no_drops", 64'(drop_cnt[1]), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
